spi_device_bus_ctrl: RTL and testbench

Sits directly downstream of the SPI synchroniser in the sys_clk domain. It consumes the synchronised chip-select, address, address-valid pulse and read/write flag, and runs one single-word transaction on the system register bus using a req/ack handshake. Read data and completion status go back to the SPI shift logic. A timeout guards against a bus that never acknowledges.

---
 rtl/spi_device_bus_ctrl.sv | 160 ++++++++++++++++
 tb/tb_spi_device_bus_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_device_bus_ctrl.sv
// SPI-to-register-bus bridge: runs one req/ack bus word per SPI address/data phase, with a bus timeout.
// Optional burst auto-increment is compiled in by defining SPI_BUS_AUTOINC_EN.
module spi_device_bus_ctrl #(
   parameter int unsigned           ADDR_WIDTH     = 32,
   parameter int unsigned           DATA_WIDTH     = 32,
   parameter int unsigned           TIMEOUT_CYCLES = 256,
   parameter logic [DATA_WIDTH-1:0] READ_ERR_VALUE = DATA_WIDTH'(32'hDEAD_BEEF),
   parameter int unsigned           ADDR_INC       = 4
) (
   input  logic                  sys_clk,
   input  logic                  rst,
   input  logic                  cs_sync,
   input  logic [ADDR_WIDTH-1:0] address_sync,
   input  logic                  address_valid_sync,
   input  logic                  rd_wr_sync,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  wdata_valid_sync,
   input  logic                  rd_next_sync,
   output logic                  bus_req,
   output logic                  bus_we,
   output logic [ADDR_WIDTH-1:0] bus_addr,
   output logic [DATA_WIDTH-1:0] bus_wdata,
   input  logic                  bus_ack,
   input  logic [DATA_WIDTH-1:0] bus_rdata,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  rdata_valid,
   output logic                  busy,
   output logic                  err
);

   localparam int unsigned           CNT_W     = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(ADDR_INC);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_WAIT = 3'd1,
      RD_REQ  = 3'd2,
      WR_REQ  = 3'd3,
      RD_NEXT = 3'd4
   } state_t;

   state_t                  state, state_nxt;
   logic [CNT_W-1:0]        to_cnt, cnt_nxt;
   logic [ADDR_WIDTH-1:0]   addr_nxt;
   logic [DATA_WIDTH-1:0]   wdata_nxt;
   logic [DATA_WIDTH-1:0]   rdata_nxt;
   logic                    rvalid_nxt;
   logic                    err_nxt;
   logic                    is_rd;

   // State register plus registered copies of everything derived from the next state
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         to_cnt      <= '0;
         bus_req     <= 1'b0;
         bus_we      <= 1'b0;
         bus_addr    <= '0;
         bus_wdata   <= '0;
         rdata       <= '0;
         rdata_valid <= 1'b0;
         busy        <= 1'b0;
         err         <= 1'b0;
      end else begin
         state       <= state_nxt;
         to_cnt      <= cnt_nxt;
         bus_req     <= (state_nxt == RD_REQ) || (state_nxt == WR_REQ);
         bus_we      <= (state_nxt == WR_REQ);
         bus_addr    <= addr_nxt;
         bus_wdata   <= wdata_nxt;
         rdata       <= rdata_nxt;
         rdata_valid <= rvalid_nxt;
         busy        <= (state_nxt != IDLE);
         err         <= err_nxt;
      end
   end

   // Next-state and next-output logic; the timeout counter is zero on every state entry
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = '0;
      addr_nxt   = bus_addr;
      wdata_nxt  = bus_wdata;
      rdata_nxt  = rdata;
      rvalid_nxt = 1'b0;
      err_nxt    = err;
      is_rd      = (state == RD_REQ);

      case (state)
         IDLE: begin
            if (address_valid_sync && !cs_sync) begin
               addr_nxt  = address_sync;
               err_nxt   = 1'b0;
               state_nxt = rd_wr_sync ? RD_REQ : WR_WAIT;
            end
         end

         WR_WAIT: begin
            if (wdata_valid_sync) begin
               wdata_nxt = wdata;
               state_nxt = WR_REQ;
            end else if (cs_sync) begin
               state_nxt = IDLE;
            end
         end

         RD_REQ, WR_REQ: begin
            if (bus_ack) begin
               if (is_rd) begin
                  rdata_nxt  = bus_rdata;
                  rvalid_nxt = 1'b1;
               end
               state_nxt = IDLE;
`ifdef SPI_BUS_AUTOINC_EN
               if (!cs_sync) begin
                  if (is_rd) begin
                     state_nxt = RD_NEXT;
                  end else begin
                     addr_nxt  = bus_addr + ADDR_STEP;
                     state_nxt = WR_WAIT;
                  end
               end
`endif
            end else if (to_cnt == CNT_LAST) begin
               err_nxt   = 1'b1;
               state_nxt = IDLE;
               if (is_rd) begin
                  rdata_nxt  = READ_ERR_VALUE;
                  rvalid_nxt = 1'b1;
               end
            end else begin
               cnt_nxt = to_cnt + CNT_W'(1);
            end
         end

         RD_NEXT: begin
`ifdef SPI_BUS_AUTOINC_EN
            if (rd_next_sync) begin
               addr_nxt  = bus_addr + ADDR_STEP;
               state_nxt = RD_REQ;
            end else if (cs_sync) begin
               state_nxt = IDLE;
            end
`else
            state_nxt = IDLE;
`endif
         end

         default: state_nxt = IDLE;
      endcase
   end

`ifndef SPI_BUS_AUTOINC_EN
   // Burst inputs have no function without auto-increment
   logic unused_burst;
   assign unused_burst = ^{rd_next_sync, ADDR_STEP};
`endif

endmodule

// File: tb/tb_spi_device_bus_ctrl.sv
// Directed bench for spi_device_bus_ctrl: transaction-level expected-output model checked every cycle,
// plus literal checks for the listed scenarios. Burst cases run when SPI_BUS_AUTOINC_EN is defined.
module tb_spi_device_bus_ctrl;

   localparam int unsigned AW  = 32;
   localparam int unsigned DW  = 32;
   localparam int unsigned TO  = 8;
   localparam int unsigned INC = 4;
   localparam logic [DW-1:0] ERRV = 32'hDEAD_BEEF;

   logic          sys_clk = 1'b0;
   logic          rst;
   logic          cs_sync;
   logic [AW-1:0] address_sync;
   logic          address_valid_sync;
   logic          rd_wr_sync;
   logic [DW-1:0] wdata;
   logic          wdata_valid_sync;
   logic          rd_next_sync;
   logic          bus_req;
   logic          bus_we;
   logic [AW-1:0] bus_addr;
   logic [DW-1:0] bus_wdata;
   logic          bus_ack;
   logic [DW-1:0] bus_rdata;
   logic [DW-1:0] rdata;
   logic          rdata_valid;
   logic          busy;
   logic          err;

   spi_device_bus_ctrl #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO),
      .READ_ERR_VALUE(ERRV), .ADDR_INC(INC)
   ) dut (
      .sys_clk(sys_clk), .rst(rst), .cs_sync(cs_sync),
      .address_sync(address_sync), .address_valid_sync(address_valid_sync),
      .rd_wr_sync(rd_wr_sync), .wdata(wdata), .wdata_valid_sync(wdata_valid_sync),
      .rd_next_sync(rd_next_sync), .bus_req(bus_req), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
      .bus_rdata(bus_rdata), .rdata(rdata), .rdata_valid(rdata_valid),
      .busy(busy), .err(err)
   );

   always #5 sys_clk = ~sys_clk;

   // Expected outputs for the current cycle, maintained by the transaction tasks
   logic          exp_req, exp_we, exp_rvalid, exp_busy, exp_err;
   logic [AW-1:0] exp_addr;
   logic [DW-1:0] exp_wdata, exp_rdata;
   logic          cur_rd;
   logic          burst_rd;
   bit            check_en = 1'b0;
   int            checks = 0;
   int            errors = 0;
   int            req_cycles = 0;
   int            n;
   int            base;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   always @(negedge sys_clk) begin
      if (bus_req === 1'b1) req_cycles++;
      if (check_en) begin
         chk("bus_req", 64'(bus_req), 64'(exp_req));
         chk("bus_we", 64'(bus_we), 64'(exp_we));
         chk("bus_addr", 64'(bus_addr), 64'(exp_addr));
         chk("bus_wdata", 64'(bus_wdata), 64'(exp_wdata));
         chk("rdata", 64'(rdata), 64'(exp_rdata));
         chk("rdata_valid", 64'(rdata_valid), 64'(exp_rvalid));
         chk("busy", 64'(busy), 64'(exp_busy));
         chk("err", 64'(err), 64'(exp_err));
      end
   end

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic model_reset();
      exp_req = 1'b0; exp_we = 1'b0; exp_rvalid = 1'b0; exp_busy = 1'b0; exp_err = 1'b0;
      exp_addr = '0; exp_wdata = '0; exp_rdata = '0;
      cur_rd = 1'b0; burst_rd = 1'b0;
   endtask

   // Accepted address phase from IDLE
   task automatic send_addr(input logic [AW-1:0] a, input logic rd);
      cs_sync = 1'b0; address_sync = a; rd_wr_sync = rd; address_valid_sync = 1'b1;
      tick();
      address_valid_sync = 1'b0; address_sync = ~a; rd_wr_sync = ~rd;
      exp_addr = a; exp_err = 1'b0; exp_busy = 1'b1; exp_req = rd; exp_we = 1'b0;
      cur_rd = rd;
   endtask

   // Write word after `gap` idle cycles in the write-wait phase
   task automatic send_wdata(input logic [DW-1:0] d, input int gap);
      repeat (gap) tick();
      wdata = d; wdata_valid_sync = 1'b1;
      tick();
      wdata_valid_sync = 1'b0; wdata = ~d;
      exp_wdata = d; exp_req = 1'b1; exp_we = 1'b1; cur_rd = 1'b0;
   endtask

   // Bus ack after `ack_after` waiting cycles (>= TO means never); returns cycles req was seen high
   task automatic wait_ack(input int ack_after, input logic [DW-1:0] d, input logic cs_val,
                           output int nreq);
      int b;
      b = req_cycles;
      cs_sync = cs_val;
      bus_rdata = d;
      if (ack_after >= int'(TO)) begin
         repeat (TO) tick();
         exp_req = 1'b0; exp_we = 1'b0; exp_busy = 1'b0; exp_err = 1'b1;
         if (cur_rd) begin exp_rdata = ERRV; exp_rvalid = 1'b1; end
      end else begin
         repeat (ack_after) tick();
         bus_ack = 1'b1;
         tick();
         bus_ack = 1'b0; bus_rdata = ~d;
         exp_req = 1'b0; exp_we = 1'b0; exp_busy = 1'b0;
         if (cur_rd) begin exp_rdata = d; exp_rvalid = 1'b1; end
`ifdef SPI_BUS_AUTOINC_EN
         if (!cs_val) begin
            exp_busy = 1'b1;
            if (cur_rd) burst_rd = 1'b1;
            else exp_addr = exp_addr + AW'(INC);
         end
`endif
      end
      nreq = req_cycles - b;
      tick();
      exp_rvalid = 1'b0;
   endtask

   task automatic end_cs();
      cs_sync = 1'b1;
      tick();
      exp_busy = 1'b0; exp_req = 1'b0; exp_we = 1'b0; burst_rd = 1'b0;
   endtask

   task automatic rd_next_pulse();
      rd_next_sync = 1'b1;
      tick();
      rd_next_sync = 1'b0;
      if (burst_rd) begin
         exp_addr = exp_addr + AW'(INC); exp_req = 1'b1; exp_busy = 1'b1;
         cur_rd = 1'b1; burst_rd = 1'b0;
      end
   endtask

   initial begin
      rst = 1'b1; cs_sync = 1'b1; address_sync = '0; address_valid_sync = 1'b0;
      rd_wr_sync = 1'b0; wdata = '0; wdata_valid_sync = 1'b0; rd_next_sync = 1'b0;
      bus_ack = 1'b0; bus_rdata = '0;
      model_reset();
      tick();
      check_en = 1'b1;
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_req", 64'(bus_req), 64'd0);
      tick();
      rst = 1'b0;
      tick();

      // Read, ack 3 cycles after req
      send_addr(32'h0000_1000, 1'b1);
      chk("rd_req_n1", 64'(bus_req), 64'd1);
      chk("rd_addr", 64'(bus_addr), 64'h1000);
      wait_ack(3, 32'hCAFE_F00D, 1'b0, n);
      chk("rd_req_cycles", 64'(n), 64'd4);
      chk("rd_rdata", 64'(rdata), 64'hCAFE_F00D);

      // Write, ack after 1 cycle
      send_addr(32'h0000_0020, 1'b0);
      send_wdata(32'h1234_5678, 2);
      chk("wr_we", 64'(bus_we), 64'd1);
      chk("wr_wdata", 64'(bus_wdata), 64'h1234_5678);
      wait_ack(1, 32'h0, 1'b0, n);
      chk("wr_req_cycles", 64'(n), 64'd2);
      chk("wr_err", 64'(err), 64'd0);
      end_cs();
      rd_next_pulse();

      // Read timeout
      send_addr(32'h0000_2000, 1'b1);
      wait_ack(TO, 32'h0, 1'b0, n);
      chk("to_req_cycles", 64'(n), 64'd8);
      chk("to_rdata", 64'(rdata), 64'hDEAD_BEEF);
      chk("to_err", 64'(err), 64'd1);

      // Ignored events in IDLE
      cs_sync = 1'b1; address_sync = 32'h7777_0000; address_valid_sync = 1'b1; rd_wr_sync = 1'b1;
      tick();
      address_valid_sync = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h0BAD_0BAD;
      tick();
      bus_ack = 1'b0; cs_sync = 1'b0; wdata = 32'hFACE_FACE; wdata_valid_sync = 1'b1;
      tick();
      wdata_valid_sync = 1'b0;
      chk("ign_err_sticky", 64'(err), 64'd1);
      chk("ign_addr", 64'(bus_addr), 64'h2000);

      // err clears on accepted address; cs rises in WR_WAIT, stray address dropped
      base = req_cycles;
      send_addr(32'h0000_3000, 1'b0);
      chk("err_cleared", 64'(err), 64'd0);
      address_sync = 32'h9999_9999; address_valid_sync = 1'b1; rd_wr_sync = 1'b1;
      tick();
      address_valid_sync = 1'b0;
      end_cs();
      tick();
      chk("wrwait_abort_noreq", 64'(req_cycles - base), 64'd0);
      chk("wrwait_abort_idle", 64'(busy), 64'd0);

      // cs rises during RD_REQ: ack still honoured
      send_addr(32'h0000_4000, 1'b1);
      address_sync = 32'h5555_5555; address_valid_sync = 1'b1;
      tick();
      address_valid_sync = 1'b0;
      wait_ack(1, 32'h55AA_55AA, 1'b1, n);
      chk("cs_rd_rdata", 64'(rdata), 64'h55AA_55AA);
      chk("cs_rd_idle", 64'(busy), 64'd0);

      // Write timeout: err sets, rdata untouched
      send_addr(32'h0000_5000, 1'b0);
      send_wdata(32'hA5A5_0001, 0);
      wait_ack(TO, 32'h0, 1'b0, n);
      chk("wto_req_cycles", 64'(n), 64'd8);
      chk("wto_rdata", 64'(rdata), 64'h55AA_55AA);

      // Reset in the middle of a read
      send_addr(32'h0000_0300, 1'b1);
      tick();
      rst = 1'b1;
      #1;
      chk("midrst_req", 64'(bus_req), 64'd0);
      chk("midrst_addr", 64'(bus_addr), 64'd0);
      chk("midrst_rdata", 64'(rdata), 64'd0);
      model_reset();
      tick();
      rst = 1'b0;
      tick();

`ifdef SPI_BUS_AUTOINC_EN
      // Write burst wrapping through zero
      send_addr(32'hFFFF_FFFC, 1'b0);
      send_wdata(32'h0000_00A1, 0);
      wait_ack(1, 32'h0, 1'b0, n);
      chk("burst_wrap_wait", 64'(bus_addr), 64'h0);
      send_wdata(32'h0000_00B2, 1);
      chk("burst_wrap_req", 64'(bus_addr), 64'h0);
      chk("burst_wr2_req", 64'(bus_req), 64'd1);
      wait_ack(0, 32'h0, 1'b1, n);

      // Read then rd_next
      send_addr(32'h0000_0100, 1'b1);
      wait_ack(2, 32'h1111_1111, 1'b0, n);
      chk("burst_rd_busy", 64'(busy), 64'd1);
      rd_next_pulse();
      chk("burst_rd2_addr", 64'(bus_addr), 64'h104);
      wait_ack(0, 32'h2222_2222, 1'b0, n);
      chk("burst_rd2_rdata", 64'(rdata), 64'h2222_2222);
      end_cs();
      tick();
`endif

      check_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
